// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester arbiter.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_rrpick.sv
// Round-robin picker: first requester at or after last+1 (mod NM) wins, one-hot grant.
module apb_rrpick #(
  parameter int unsigned NM = 2,
  parameter int unsigned GW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last,
  output logic [NM-1:0] grant
);

  logic [GW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NM; i++) begin
      idx = GW'((32'(last) + i) % NM);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Multi-requester APB master: round-robin grant, one transfer at a time,
// optional ACCESS-phase timeout.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned NM          = 2,
  parameter int unsigned OPT_TIMEOUT = 0
) (
  input  logic                PCLK,
  input  logic                i_reset,
  input  logic [NM-1:0]       i_valid,
  output logic [NM-1:0]       o_ready,
  input  logic [NM*AW-1:0]    i_addr,
  input  logic [NM-1:0]       i_write,
  input  logic [NM*DW-1:0]    i_wdata,
  input  logic [NM*DW/8-1:0]  i_wstrb,
  input  logic [NM*3-1:0]     i_prot,
  output logic [NM-1:0]       o_rvalid,
  output logic [DW-1:0]       o_rdata,
  output logic                o_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [AW-1:0]       PADDR,
  output logic [DW-1:0]       PWDATA,
  output logic [DW/8-1:0]     PWSTRB,
  output logic [2:0]          PPROT,
  input  logic                PREADY,
  input  logic [DW-1:0]       PRDATA,
  input  logic                PSLVERR
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned GW = $clog2(NM);

  apb_state_e    state, state_d;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] gidx_c;
  logic [NM-1:0] grant_c;
  logic          grant_en_c;
  logic          done_c;
  logic          timeout_c;

  logic [AW-1:0] addr_a  [NM];
  logic [DW-1:0] wdata_a [NM];
  logic [SW-1:0] wstrb_a [NM];
  logic [2:0]    prot_a  [NM];

  // Unpack the flat per-requester buses
  for (genvar k = 0; k < NM; k++) begin : g_unpack
    assign addr_a[k]  = i_addr[k*AW +: AW];
    assign wdata_a[k] = i_wdata[k*DW +: DW];
    assign wstrb_a[k] = i_wstrb[k*SW +: SW];
    assign prot_a[k]  = i_prot[k*3 +: 3];
  end

  apb_rrpick #(.NM(NM), .GW(GW)) u_rrpick (
    .req   (i_valid),
    .last  (last_grant),
    .grant (grant_c)
  );

  always_comb begin
    gidx_c = '0;
    for (int unsigned k = 0; k < NM; k++) begin
      if (grant_c[GW'(k)]) gidx_c = GW'(k);
    end
  end

  assign o_ready = grant_en_c ? grant_c : '0;

  // ACCESS-phase watchdog, only built when a limit is configured
  if (OPT_TIMEOUT > 0) begin : g_timeout
    localparam int unsigned TW = $clog2(OPT_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge PCLK) begin
      if (i_reset)                               to_cnt <= '0;
      else if (state == ST_ACCESS && !PREADY)    to_cnt <= to_cnt + TW'(1);
      else                                       to_cnt <= '0;
    end

    assign timeout_c = (state == ST_ACCESS) && !PREADY &&
                       (to_cnt == TW'(OPT_TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_c = 1'b0;
  end

  always_ff @(posedge PCLK) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d    = state;
    grant_en_c = 1'b0;
    done_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!i_reset && |i_valid) begin
          grant_en_c = 1'b1;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PSEL && PENABLE && PREADY) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered APB master outputs and requester response
  always_ff @(posedge PCLK) begin
    if (i_reset) begin
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PWSTRB     <= '0;
      PPROT      <= '0;
      o_rvalid   <= '0;
      o_rdata    <= '0;
      o_err      <= 1'b0;
      last_grant <= GW'(NM - 1);
    end else begin
      PSEL     <= (state_d != ST_IDLE);
      PENABLE  <= (state_d == ST_ACCESS);
      o_rvalid <= '0;
      if (grant_en_c) begin
        last_grant <= gidx_c;
        PADDR      <= addr_a[gidx_c];
        PWRITE     <= i_write[gidx_c];
        PWDATA     <= i_write[gidx_c] ? wdata_a[gidx_c] : '0;
        PWSTRB     <= i_write[gidx_c] ? wstrb_a[gidx_c] : '0;
        PPROT      <= prot_a[gidx_c];
      end
      if (done_c) begin
        o_rvalid <= NM'(1) << last_grant;
        o_rdata  <= PRDATA;
        o_err    <= PSLVERR;
      end else if (timeout_c) begin
        o_rvalid <= NM'(1) << last_grant;
        o_rdata  <= '0;
        o_err    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, APB address width.
REQ-002 SHALL have parameter DW, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter NM, default 2, requester count (2..4).
REQ-004 SHALL have parameter OPT_TIMEOUT, default 0, max ACCESS-phase cycles before abort (0 = none).
REQ-005 SHALL have port PCLK  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port i_valid  in  NM  per-requester request valid.
REQ-008 SHALL have port o_ready  out  NM  per-requester request accepted this cycle.
REQ-009 SHALL have port i_addr  in  NM*AW  per-requester address, requester k at bits [k*AW +: AW].
REQ-010 SHALL have port i_write  in  NM  per-requester write (1) / read (0).
REQ-011 SHALL have port i_wdata  in  NM*DW  per-requester write data.
REQ-012 SHALL have port i_wstrb  in  NM*DW/8  per-requester byte strobes.
REQ-013 SHALL have port i_prot  in  NM*3  per-requester protection bits.
REQ-014 SHALL have port o_rvalid  out  NM  per-requester one-cycle response strobe.
REQ-015 SHALL have port o_rdata  out  DW  response data, shared, valid with o_rvalid.
REQ-016 SHALL have port o_err  out  1  response error, shared, valid with o_rvalid.
REQ-017 SHALL have ports PSEL, PENABLE, PWRITE  out  1 each  APB master controls.
REQ-018 SHALL have ports PADDR (AW), PWDATA (DW), PWSTRB (DW/8), PPROT (3)  out  APB master payload.
REQ-019 SHALL have ports PREADY (1), PRDATA (DW), PSLVERR (1)  in  APB completer response.

Function
REQ-020 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all APB outputs registered.
REQ-021 In IDLE with any i_valid set, SHALL grant one requester g, assert o_ready[g] combinationally that cycle, latch its addr/write/wdata/wstrb/prot into APB outputs, enter SETUP.
REQ-022 SETUP: PSEL=1, PENABLE=0; SHALL enter ACCESS next cycle unconditionally.
REQ-023 ACCESS: PSEL=1, PENABLE=1; PADDR, PWRITE, PPROT, PWDATA, PWSTRB SHALL hold stable until exit.
REQ-024 On PREADY in ACCESS, SHALL drop PSEL/PENABLE next cycle, pulse o_rvalid[g] one cycle, set o_rdata=PRDATA and o_err=PSLVERR as captured, return to IDLE.
REQ-025 Latency: accept at cycle t -> PSEL at t+1, PENABLE at t+2, o_rvalid at t+3 with zero-wait slave; minimum 3 cycles between grants.
REQ-026 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NM; single requester SHALL be granted every opportunity.
REQ-027 o_ready SHALL be all-zero outside IDLE; at most one bit set per cycle.
REQ-028 Reads SHALL drive PWSTRB=0 and PWDATA=0.
REQ-029 PSLVERR and PRDATA SHALL be ignored unless PSEL&&PENABLE&&PREADY.
REQ-030 If OPT_TIMEOUT>0 and ACCESS lasts OPT_TIMEOUT cycles without PREADY, SHALL drop PSEL/PENABLE, pulse o_rvalid[g] with o_err=1, o_rdata=0, return to IDLE.
REQ-031 PREADY arriving on the timeout cycle SHALL win (normal completion).
REQ-032 PSEL SHALL never fall while PENABLE=1 and PREADY=0, except on timeout.

Reset
REQ-033 On i_reset: state=IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA, PWSTRB, PPROT=0; o_rvalid=0, o_rdata=0, o_err=0; last_grant=NM-1; timeout counter=0.
REQ-034 Reset mid-transfer SHALL abandon it: APB outputs idle next cycle, no o_rvalid issued.
REQ-035 o_ready SHALL be 0 while i_reset is asserted.

Structure
REQ-036 FSM state encodings (IDLE/SETUP/ACCESS) SHALL live in shared package apb_pkg.
REQ-037 Round-robin selection SHALL be sub-module apb_rrpick (inputs request vector, last grant; output one-hot grant).
REQ-038 Timeout counter width SHALL be $clog2(OPT_TIMEOUT+1); absent when OPT_TIMEOUT=0.

Verification
REQ-039 Req0 write addr 0x10 data 0xA5A5A5A5, PREADY=1 -> PSEL t+1, PENABLE t+2, o_rvalid[0] t+3, o_err=0.
REQ-040 Req0 and req1 valid continuously, zero-wait -> grants alternate 0,1,0,1; first grant 0 after reset.
REQ-041 Read, PREADY held low 3 cycles then PRDATA=0x12345678, PSLVERR=1 -> payload stable 3 stall cycles, o_rdata=0x12345678, o_err=1.
REQ-042 OPT_TIMEOUT=4, PREADY never -> PSEL falls after 4 ACCESS cycles, o_rvalid with o_err=1, o_rdata=0.
REQ-043 i_reset asserted during ACCESS -> PSEL=PENABLE=0 next cycle, no o_rvalid, next grant to requester 0.
REQ-044 Every run SHALL check APB master rules: PENABLE only after one SETUP cycle, payload stable until PREADY, PSEL low during reset.
